// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Raster timing generator for a 640x480@60 VGA display with a registered
// pixel output stage. The raw h/v counters are exported as VGA_col/VGA_row
// so the pixel drivers can compute a colour combinationally. That colour is
// captured one pixel later, together with blanking and both syncs, so that
// everything reaching the DAC pins stays aligned to the same pixel.
//
// rst_l asserts asynchronously. Its release is expected to be synchronous
// to clk, which the board-level reset logic provides.

module vga_timing_ctrl #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [23:0] pixel_color,
    output logic [9:0]  VGA_row,
    output logic [9:0]  VGA_col,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start,
    output logic        vblank
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int CNT_W   = 10;
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Counter state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [CNT_W-1:0] h_cnt_reg,   h_cnt_next;
    logic [CNT_W-1:0] v_cnt_reg,   v_cnt_next;
    logic             vga_clk_reg, vga_clk_next;

    logic pix_en;
    logic h_last;
    logic v_last;

    // Pixel strobe, end-of-line/frame detection and next counter values
    always_comb begin
        pix_en       = (div_cnt_reg == DIV_LAST);
        h_last       = (h_cnt_reg == H_LAST);
        v_last       = (v_cnt_reg == V_LAST);

        div_cnt_next = pix_en ? '0 : div_cnt_reg + 1'b1;
        h_cnt_next   = h_cnt_reg;
        v_cnt_next   = v_cnt_reg;

        if (pix_en) begin
            if (h_last) begin
                h_cnt_next = '0;
                v_cnt_next = v_last ? '0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_next = h_cnt_reg + 10'd1;
            end
        end

        // DAC clock follows the divider phase the flops will hold after this
        // edge, so its rising edge lands half a pixel after the data changes.
        vga_clk_next = (div_cnt_next >= DIV_HALF);
    end

    // Divider, raster counters and DAC clock registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_cnt_reg <= '0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            vga_clk_reg <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            vga_clk_reg <= vga_clk_next;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: decode the pixel currently on the counters, register on
    // the next pixel strobe. One pixel of latency for colour, blank and sync.
    // ------------------------------------------------------------------
    logic vis;
    logic hs_active;
    logic vs_active;

    // Visibility and sync-window decode of the current raster position
    always_comb begin
        vis       = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
        hs_active = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
        vs_active = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    end

    logic blank_n_reg;
    logic hs_reg;
    logic vs_reg;

    // Blank and sync registers; syncs idle high
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            blank_n_reg <= 1'b0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
        end else if (pix_en) begin
            blank_n_reg <= vis;
            hs_reg      <= ~hs_active;
            vs_reg      <= ~vs_active;
        end
    end

    // One colour register per channel: R, G, B from the top byte down.
    // The colour is forced to zero outside the visible area so the DAC
    // never sees pixel-driver output during the porches and syncs.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] chan_reg;

            // Capture this channel of pixel_color on the pixel strobe
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    chan_reg <= '0;
                end else if (pix_en) begin
                    chan_reg <= vis ? pixel_color[8*(2-gi) +: 8] : 8'h00;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Port mapping
    // ------------------------------------------------------------------
    assign VGA_row     = v_cnt_reg;
    assign VGA_col     = h_cnt_reg;
    assign VGA_R       = g_chan[0].chan_reg;
    assign VGA_G       = g_chan[1].chan_reg;
    assign VGA_B       = g_chan[2].chan_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_reg;

    // Wrap from the last pixel of the last line back to (0,0). Counters sit
    // at (0,0) out of reset, so the restart after reset never pulses this.
    assign frame_start = pix_en && h_last && v_last;

    // Game logic may update state while the raster is below the visible area
    assign vblank      = (v_cnt_reg >= V_VIS_END);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
// Directed bench for vga_timing_ctrl using a shrunken raster so that several
// full frames fit in a short run. A cycle model tracks divider and counters;
// on every pixel strobe the expected registered pixel is pushed to a
// scoreboard queue and popped once the DUT has clocked it out.

module tb_vga_timing_ctrl;

    localparam int CD  = 4;
    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 3;
    localparam int VV  = 12;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int LINE_CLKS  = HT * CD;
    localparam int FRAME_CLKS = LINE_CLKS * VT;

    logic        clk;
    logic        rst_l;
    logic [23:0] pixel_color;
    logic [9:0]  VGA_row;
    logic [9:0]  VGA_col;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;
    logic        VGA_CLK;
    logic        frame_start;
    logic        vblank;

    vga_timing_ctrl #(
        .CLK_DIV  (CD),
        .H_VISIBLE(HV),
        .H_FP     (HF),
        .H_SYNC   (HSW),
        .H_BP     (HB),
        .V_VISIBLE(VV),
        .V_FP     (VF),
        .V_SYNC   (VSW),
        .V_BP     (VB)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .pixel_color(pixel_color),
        .VGA_row    (VGA_row),
        .VGA_col    (VGA_col),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_CLK    (VGA_CLK),
        .frame_start(frame_start),
        .vblank     (vblank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        blank_n;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
    } pix_t;

    pix_t sb_q[$];
    pix_t cur_exp;

    int m_div, m_h, m_v;
    int mode;
    int n_total, n_pass, n_fail;
    int cyc;
    int hs_have, hs_fall_cyc, hs_low;
    logic hs_prev;
    int fs_have, fs_cyc, vb_clks, vs_low, fs_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0;
        m_h   = 0;
        m_v   = 0;
        sb_q.delete();
        cur_exp     = '{blank_n: 1'b0, rgb: 24'h0, hs: 1'b1, vs: 1'b1};
        hs_have     = 0;
        hs_low      = 0;
        hs_prev     = 1'b1;
        fs_have     = 0;
        vb_clks     = 0;
        vs_low      = 0;
        fs_count    = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"},     32'(VGA_row), 0);
        chk({tag, "_col"},     32'(VGA_col), 0);
        chk({tag, "_rgb"},     32'({VGA_R, VGA_G, VGA_B}), 0);
        chk({tag, "_blank_n"}, 32'(VGA_BLANK_N), 0);
        chk({tag, "_hs"},      32'(VGA_HS), 1);
        chk({tag, "_vs"},      32'(VGA_VS), 1);
        chk({tag, "_vga_clk"}, 32'(VGA_CLK), 0);
        chk({tag, "_fs"},      32'(frame_start), 0);
        chk({tag, "_sync_n"},  32'(VGA_SYNC_N), 0);
    endtask

    function automatic pix_t expect_pix(input int h, input int v, input logic [23:0] color);
        pix_t p;
        logic vis;
        vis       = (h < HV) && (v < VV);
        p.blank_n = vis;
        p.rgb     = vis ? color : 24'h0;
        p.hs      = !((h >= HV + HF) && (h < HV + HF + HSW));
        p.vs      = !((v >= VV + VF) && (v < VV + VF + VSW));
        return p;
    endfunction

    // One clock of free-running raster: entered and left at a negedge.
    task automatic cycle();
        bit          pe;
        logic [23:0] good;
        pe   = (m_div == CD - 1);
        good = (mode == 0) ? {m_v[7:0], m_h[7:0], 8'hA5} : 24'hFFFFFF;
        // Colour is only meaningful on the strobe; feed junk otherwise.
        pixel_color = pe ? good : 24'($urandom());

        chk("row",     32'(VGA_row), m_v);
        chk("col",     32'(VGA_col), m_h);
        chk("vga_clk", 32'(VGA_CLK), (m_div >= CD / 2) ? 1 : 0);
        chk("vblank",  32'(vblank),  (m_v >= VV) ? 1 : 0);
        chk("frame_start", 32'(frame_start),
            (pe && m_h == HT - 1 && m_v == VT - 1) ? 1 : 0);
        chk("blank_n", 32'(VGA_BLANK_N), 32'(cur_exp.blank_n));
        chk("rgb",     32'({VGA_R, VGA_G, VGA_B}), 32'(cur_exp.rgb));
        chk("hs",      32'(VGA_HS), 32'(cur_exp.hs));
        chk("vs",      32'(VGA_VS), 32'(cur_exp.vs));

        if (VGA_HS === 1'b0) hs_low++;
        if (hs_prev === 1'b1 && VGA_HS === 1'b0) begin
            if (hs_have != 0) begin
                chk("hs_period",   32'(cyc - hs_fall_cyc), LINE_CLKS);
                chk("hs_low_clks", 32'(hs_low), HSW * CD);
            end
            hs_have     = 1;
            hs_fall_cyc = cyc;
            hs_low      = 0;
        end
        hs_prev = VGA_HS;

        if (vblank === 1'b1) vb_clks++;
        if (VGA_VS === 1'b0) vs_low++;
        if (frame_start === 1'b1) begin
            if (fs_have != 0) begin
                chk("fs_spacing",  32'(cyc - fs_cyc), FRAME_CLKS);
                chk("vblank_clks", 32'(vb_clks), (VT - VV) * LINE_CLKS);
                chk("vs_low_clks", 32'(vs_low), VSW * LINE_CLKS);
            end
            fs_have = 1;
            fs_cyc  = cyc;
            vb_clks = 0;
            vs_low  = 0;
            fs_count++;
        end

        if (pe) sb_q.push_back(expect_pix(m_h, m_v, good));

        @(posedge clk);
        if (pe) begin
            if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        m_div = pe ? 0 : m_div + 1;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int found;
        n_total     = 0;
        n_pass      = 0;
        n_fail      = 0;
        cyc         = 0;
        mode        = 0;
        pixel_color = 24'h0;
        rst_l       = 1'b0;
        model_reset();

        // Step 1: power-on reset, then first pixel strobe CD clocks after release
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst_l = 1'b1;
        repeat (CD - 1) cycle();
        chk("col_before_first_pix", 32'(VGA_col), 0);
        cycle();
        chk("col_after_first_pix", 32'(VGA_col), 1);
        $display("step1 reset/release done: checks=%0d", n_total);

        // Steps 2-4: two frames with the {row,col,A5} pattern
        repeat (2 * FRAME_CLKS) cycle();
        chk("fs_count_2frames", 32'(fs_count), 2);
        $display("step2-4 free-run 2 frames done: checks=%0d", n_total);

        // Step 5: constant white, must be blanked outside the visible area
        mode = 1;
        repeat (FRAME_CLKS) cycle();
        $display("step5 white frame done: checks=%0d", n_total);

        // Step 6: reset in the middle of a visible pixel
        mode  = 0;
        found = 0;
        n     = 0;
        while (found == 0 && n < 2 * FRAME_CLKS) begin
            if (m_v == 7 && m_h == 10 && m_div == 2) found = 1;
            else begin
                cycle();
                n++;
            end
        end
        chk("reach_mid_frame", 32'(found), 1);
        chk("pre_reset_blank_n", 32'(VGA_BLANK_N), 1);
        rst_l = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_reset();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset_outputs("hold");
        end
        rst_l = 1'b1;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME_CLKS) begin
            cycle();
            n++;
        end
        chk("restart_fs_delay", 32'(n + 1), FRAME_CLKS);
        repeat (4 * CD) cycle();
        chk("restart_row_after_wrap", 32'(VGA_row), 0);
        $display("step6 mid-frame reset done: checks=%0d", n_total);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
